// File: rtl/vedic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vedic_pkg
//  Description : Shared widths, constants and state encoding for the Vedic
//                arithmetic datapath (32-by-16 restoring divider).
//  Revision    : 1.0 - initial release
// ============================================================================
package vedic_pkg;

    localparam int DIVIDEND_W = 32;
    localparam int DIVISOR_W  = 16;
    // Partial remainder carries one guard bit above the divisor width.
    localparam int REM_W      = DIVISOR_W + 1;
    localparam int COUNT_W    = 4;

    // Saturated quotient reported for divide-by-zero and overflow.
    localparam logic [DIVISOR_W-1:0] DIV_SAT   = 16'hFFFF;
    // Index of the final iteration; 16 iterations produce 16 quotient bits.
    localparam logic [COUNT_W-1:0]   LAST_STEP = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage : vedic_pkg
`default_nettype wire

// File: rtl/div_restore_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_restore_step
//  Description : One combinational restoring-division iteration. Shifts the
//                next dividend bit into the partial remainder, trial-subtracts
//                the divisor and keeps the difference only if non-negative.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_restore_step
    import vedic_pkg::*;
(
    input  logic [REM_W-1:0]     rem_in,
    input  logic [DIVISOR_W-1:0] quo_in,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [REM_W-1:0]     rem_out,
    output logic [DIVISOR_W-1:0] quo_out
);

    logic [REM_W-1:0] w_shifted;
    logic [REM_W-1:0] w_trial;
    logic             w_negative;
    // The guard bit of the incoming remainder is always zero because the
    // remainder is kept below the divisor; it is deliberately not consumed.
    logic             w_unused;

    assign w_unused   = rem_in[REM_W-1];
    assign w_shifted  = {rem_in[DIVISOR_W-1:0], quo_in[DIVISOR_W-1]};
    assign w_trial    = w_shifted - {1'b0, divisor};
    assign w_negative = w_trial[REM_W-1];

    // Restore on a negative trial, otherwise keep the difference.
    assign rem_out = w_negative ? w_shifted : w_trial;
    assign quo_out = {quo_in[DIVISOR_W-2:0], ~w_negative};

endmodule : div_restore_step
`default_nettype wire

// File: rtl/vedic_divider_32by16.sv
`default_nettype none
// ============================================================================
//  Module      : vedic_divider_32by16
//  Description : Sequential restoring divider, 32-bit dividend by 16-bit
//                divisor, one quotient bit per clock, valid/ready on both
//                the operand and result side. Divide-by-zero and quotient
//                overflow are detected at accept and answered in one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module vedic_divider_32by16
    import vedic_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVISOR_W-1:0]  quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    div_state_t             r_state;
    div_state_t             w_state_next;
    logic [COUNT_W-1:0]     r_count;
    logic [DIVISOR_W-1:0]   r_divisor;
    logic [REM_W-1:0]       r_rem;
    logic [DIVISOR_W-1:0]   r_quo;
    logic [DIVISOR_W-1:0]   r_quotient;
    logic [DIVISOR_W-1:0]   r_remainder;
    logic                   r_div_by_zero;
    logic                   r_overflow;

    logic                   w_accept;
    logic                   w_zero;
    logic                   w_ovf;
    logic                   w_last;
    logic                   w_out_fire;
    logic [DIVISOR_W-1:0]   w_hi;
    logic [DIVISOR_W-1:0]   w_lo;
    logic [REM_W-1:0]       w_rem_next;
    logic [DIVISOR_W-1:0]   w_quo_next;

    assign w_hi       = dividend[DIVIDEND_W-1:DIVISOR_W];
    assign w_lo       = dividend[DIVISOR_W-1:0];
    assign w_zero     = (divisor == '0);
    // A high half at or above the divisor means the quotient needs > 16 bits.
    assign w_ovf      = (w_hi >= divisor);
    assign w_accept   = in_valid && in_ready;
    assign w_last     = (r_count == LAST_STEP);
    assign w_out_fire = out_valid && out_ready;

    assign in_ready    = (r_state == IDLE) && !rst;
    assign out_valid   = (r_state == DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;
    assign overflow    = r_overflow;

    div_restore_step u_step (
        .rem_in  (r_rem),
        .quo_in  (r_quo),
        .divisor (r_divisor),
        .rem_out (w_rem_next),
        .quo_out (w_quo_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state selection: special cases skip straight to DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_zero || w_ovf) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (w_out_fire) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count       <= '0;
            r_divisor     <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_divisor <= divisor;
                        r_count   <= '0;
                        if (w_zero) begin
                            r_div_by_zero <= 1'b1;
                            r_quotient    <= DIV_SAT;
                            r_remainder   <= w_lo;
                        end else if (w_ovf) begin
                            r_overflow    <= 1'b1;
                            r_quotient    <= DIV_SAT;
                            r_remainder   <= '0;
                        end else begin
                            r_rem <= {1'b0, w_hi};
                            r_quo <= w_lo;
                        end
                    end
                end
                RUN: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count + 4'd1;
                    if (w_last) begin
                        r_quotient  <= w_quo_next;
                        r_remainder <= w_rem_next[DIVISOR_W-1:0];
                    end
                end
                DONE: begin
                    if (w_out_fire) begin
                        r_div_by_zero <= 1'b0;
                        r_overflow    <= 1'b0;
                    end
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule : vedic_divider_32by16
`default_nettype wire

// File: tb/tb_vedic_divider_32by16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vedic_divider_32by16
//  Description : Self-checking bench for vedic_divider_32by16: directed
//                vector table, backpressure, mid-run reset and randomized
//                operands against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vedic_divider_32by16;

    localparam int TIMEOUT = 40;
    localparam int N_RAND  = 2000;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] dvd;
        logic [15:0] dvs;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ov;
        int          lat;   // edges after the accept edge until out_valid
    } vec_t;

    vec_t vecs[9];

    vedic_divider_32by16 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model straight from the arithmetic definition.
    task automatic model(input logic [31:0] dvd, input logic [15:0] dvs,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic dz, output logic ov, output int lat);
        longint unsigned n, d;
        n = longint'(dvd);
        d = longint'(dvs);
        dz = 1'b0; ov = 1'b0; lat = 16;
        if (d == 0) begin
            dz = 1'b1; q = 16'hFFFF; r = dvd[15:0]; lat = 0;
        end else if (n / d > 64'hFFFF) begin
            ov = 1'b1; q = 16'hFFFF; r = 16'h0000; lat = 0;
        end else begin
            q = 16'(n / d);
            r = 16'(n % d);
        end
    endtask

    // One full transaction: accept, wait, check, optional hold, handshake.
    task automatic do_op(input logic [31:0] dvd, input logic [15:0] dvs,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic edz, input logic eov, input int elat,
                         input int hold, input bit noise);
        int n;
        logic [15:0] sq, sr;
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        n = 0;
        while (!out_valid && n < TIMEOUT) begin
            if (noise) in_valid = 1'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, elat);
        chk("quotient", {16'd0, quotient}, {16'd0, eq});
        chk("remainder", {16'd0, remainder}, {16'd0, er});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, edz});
        chk("overflow", {31'd0, overflow}, {31'd0, eov});
        chk("busy_not_ready", {31'd0, in_ready}, 32'd0);
        sq = quotient;
        sr = remainder;
        for (int k = 0; k < hold; k++) begin
            if (noise) in_valid = 1'($urandom);
            @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_q", {16'd0, quotient}, {16'd0, sq});
            chk("hold_r", {16'd0, remainder}, {16'd0, sr});
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
        chk("post_hs_ready", {31'd0, in_ready}, 32'd1);
        chk("post_hs_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    endtask

    initial begin
        logic [15:0] mq, mr, hi, dv;
        logic        mdz, mov;
        int          mlat;
        logic [31:0] dvd;

        vecs[0] = '{32'h0000_0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, 16};
        vecs[1] = '{32'hFFFE_0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16};
        vecs[2] = '{32'h1234_5678, 16'h0000, 16'hFFFF, 16'h5678, 1'b1, 1'b0, 0};
        vecs[3] = '{32'h0001_0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 0};
        vecs[4] = '{32'h0000_0000, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0, 16};
        vecs[5] = '{32'h0000_FFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16};
        vecs[6] = '{32'h0005_0000, 16'h0005, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 0};
        vecs[7] = '{32'h0004_FFFF, 16'h0005, 16'hFFFF, 16'h0004, 1'b0, 1'b0, 16};
        vecs[8] = '{32'h0000_0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;

        // Reset behaviour.
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_q_r", {quotient, remainder}, 32'd0);
        chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        chk("rst_then_ready", {31'd0, in_ready}, 32'd1);

        // out_ready high while idle does nothing.
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("idle_out_ready_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_out_ready_ready", {31'd0, in_ready}, 32'd1);

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r,
                  vecs[i].dz, vecs[i].ov, vecs[i].lat, 0, 1'b0);
        end

        // Backpressure with ignored in_valid pulses, normal and special path.
        do_op(32'h0000_0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, 16, 5, 1'b1);
        do_op(32'h1234_5678, 16'h0000, 16'hFFFF, 16'h5678, 1'b1, 1'b0, 0, 5, 1'b1);

        // Reset in the middle of an iteration sequence.
        @(negedge clk);
        dividend = 32'h00FF_0000; divisor = 16'h0100; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_q_r", {quotient, remainder}, 32'd0);
        chk("midrst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_discarded", {31'd0, out_valid}, 32'd0);
        do_op(32'h00FF_0000, 16'h0100, 16'hFF00, 16'h0000, 1'b0, 1'b0, 16, 0, 1'b0);

        // Randomized operands, mostly in the non-overflowing range.
        for (int i = 0; i < N_RAND; i++) begin
            if (i % 8 == 7) begin
                dvd = $urandom;
                dv  = 16'($urandom_range(0, 3));
                if (i % 16 == 15) dv = 16'($urandom);
            end else begin
                dv  = 16'($urandom_range(1, 65535));
                hi  = 16'($urandom % dv);
                dvd = {hi, 16'($urandom)};
            end
            model(dvd, dv, mq, mr, mdz, mov, mlat);
            do_op(dvd, dv, mq, mr, mdz, mov, mlat, 0, 1'b0);
            if (!mdz && !mov) begin
                chk("identity", 32'(quotient) * 32'(dv) + 32'(remainder), dvd);
                chk("rem_lt_div", {31'd0, (remainder < dv)}, 32'd1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_vedic_divider_32by16
`default_nettype wire
